// File: rtl/prob_tbl_pkg.sv
// ----------------------------------------------------------------------------
// prob_tbl_pkg
// Shared constants, FSM state type and helpers for the probability-table
// receiver (prob_table_rx) and its memory bank (prob_tbl_bank).
//   IDX_IDLE  : index value the host drives when it has nothing to write
//   TBL_AW    : width of one packed read address on the read bus
//   MAX_DEPTH : largest table the popcount helper can count
//   state_t   : load/commit FSM states
//   popcount  : number of set bits in a written-bitmap
// ----------------------------------------------------------------------------
package prob_tbl_pkg;

    localparam logic [31:0] IDX_IDLE  = 32'hFFFF_FFFF;
    localparam int          TBL_AW    = 6;
    localparam int          MAX_DEPTH = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_SWAP
    } state_t;

    function automatic logic [6:0] popcount(input logic [MAX_DEPTH-1:0] v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prob_table_rx_if.sv
// ----------------------------------------------------------------------------
// prob_table_rx_if
// Bus between the table loader/readers (master) and prob_table_rx (slave).
//   probability_idx : write index, IDX_IDLE when no write is offered
//   probability_in  : write data, sampled together with probability_idx
//   rd_addr         : packed read addresses, port k at [TBL_AW*k +: TBL_AW]
//   rd_data         : packed read data, port k at [DW*k +: DW]
// ----------------------------------------------------------------------------
interface prob_table_rx_if #(
    parameter int DW   = 64,
    parameter int N_RD = 10
);
    import prob_tbl_pkg::*;

    logic [31:0]          probability_idx;
    logic [DW-1:0]        probability_in;
    logic [N_RD*TBL_AW-1:0] rd_addr;
    logic [N_RD*DW-1:0]   rd_data;

    modport master (
        output probability_idx,
        output probability_in,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  probability_idx,
        input  probability_in,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/prob_tbl_bank.sv
// ----------------------------------------------------------------------------
// prob_tbl_bank
// One DEPTH x DW table bank: a single synchronous write port and N_RD
// registered read ports. Reads return the contents before a same-edge write.
//   clk, rst_n : clock and asynchronous active-low reset (read regs only)
//   we         : write enable
//   waddr      : write address
//   wdata      : write data
//   raddr      : packed read addresses, port k at [AW*k +: AW]
//   rdata      : packed registered read data, port k at [DW*k +: DW]
// ----------------------------------------------------------------------------
module prob_tbl_bank #(
    parameter int DEPTH = 64,
    parameter int DW    = 64,
    parameter int N_RD  = 10,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DW-1:0]        wdata,
    input  logic [N_RD*AW-1:0]   raddr,
    output logic [N_RD*DW-1:0]   rdata
);

    logic [DW-1:0]      mem_q [DEPTH];
    logic [N_RD*DW-1:0] rdata_d;
    logic [N_RD*DW-1:0] rdata_q;

    // Table storage is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < N_RD; k++) begin
            rdata_d[k*DW +: DW] = mem_q[raddr[k*AW +: AW]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/prob_table_rx.sv
// ----------------------------------------------------------------------------
// prob_table_rx
// Receives (probability_idx, probability_in) pairs into a shadow bank, checks
// that every entry was written, then atomically swaps shadow and active banks.
// N_RD registered read ports always serve the active bank.
//   clk, rstn       : clock, asynchronous active-low reset
//   bus (slave)     : write stream in, packed read addresses in / data out
//   table_valid     : active bank holds a complete committed table
//   load_busy       : FSM is in LOAD
//   entries_written : number of shadow entries written in the current load
//   err_range       : sticky, an index in DEPTH..IDX_IDLE-1 was seen
//   err_incomplete  : sticky, a load ended without every entry written
//   commit_count    : successful commits, wrapping
// ----------------------------------------------------------------------------
module prob_table_rx
    import prob_tbl_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DW    = 64,
    parameter int N_RD  = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    prob_table_rx_if.slave       bus,
    output logic                 table_valid,
    output logic                 load_busy,
    output logic [6:0]           entries_written,
    output logic                 err_range,
    output logic                 err_incomplete,
    output logic [15:0]          commit_count
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]        rst_sync_q;
    logic              rst_n_int;

    state_t            state_d, state_q;
    logic              bank_sel_d, bank_sel_q;
    logic              rd_sel_d, rd_sel_q;
    logic [DEPTH-1:0]  bitmap_d, bitmap_q;
    logic              table_valid_d, table_valid_q;
    logic              err_range_d, err_range_q;
    logic              err_incomplete_d, err_incomplete_q;
    logic [15:0]       commit_count_d, commit_count_q;

    logic              idx_idle;
    logic              idx_in_range;
    logic              wr_bank;
    logic              we0, we1;
    logic [AW-1:0]     waddr;
    logic [N_RD*AW-1:0] bank_raddr;
    logic [N_RD*DW-1:0] bank0_rdata, bank1_rdata;

    // Reset asserts immediately but is released on a clock edge, so all
    // state leaves reset together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    assign idx_idle     = (bus.probability_idx == IDX_IDLE);
    assign idx_in_range = (bus.probability_idx < 32'(DEPTH));
    assign waddr        = bus.probability_idx[AW-1:0];

    // The bank that becomes shadow on a swap is the one active right now, so
    // a write arriving in SWAP already targets the new shadow bank. Reads at
    // that edge still see the pre-write contents of that bank.
    assign wr_bank = (state_q == S_SWAP) ? bank_sel_q : ~bank_sel_q;
    assign we0     = idx_in_range && (wr_bank == 1'b0);
    assign we1     = idx_in_range && (wr_bank == 1'b1);

    // Next-state and register updates; the bitmap bit for an accepted write
    // is applied last so it survives the clear performed in SWAP.
    always_comb begin
        state_d          = state_q;
        bank_sel_d       = bank_sel_q;
        bitmap_d         = bitmap_q;
        table_valid_d    = table_valid_q;
        err_range_d      = err_range_q;
        err_incomplete_d = err_incomplete_q;
        commit_count_d   = commit_count_q;
        rd_sel_d         = bank_sel_q;

        if (!idx_idle && !idx_in_range) begin
            err_range_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!idx_idle) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (idx_idle) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (&bitmap_q) begin
                    state_d = S_SWAP;
                end else begin
                    err_incomplete_d = 1'b1;
                    state_d          = S_IDLE;
                end
            end
            S_SWAP: begin
                bank_sel_d     = ~bank_sel_q;
                table_valid_d  = 1'b1;
                bitmap_d       = '0;
                commit_count_d = commit_count_q + 16'd1;
                state_d        = idx_idle ? S_IDLE : S_LOAD;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (idx_in_range) begin
            bitmap_d[waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q          <= S_IDLE;
            bank_sel_q       <= 1'b0;
            rd_sel_q         <= 1'b0;
            bitmap_q         <= '0;
            table_valid_q    <= 1'b0;
            err_range_q      <= 1'b0;
            err_incomplete_q <= 1'b0;
            commit_count_q   <= '0;
        end else begin
            state_q          <= state_d;
            bank_sel_q       <= bank_sel_d;
            rd_sel_q         <= rd_sel_d;
            bitmap_q         <= bitmap_d;
            table_valid_q    <= table_valid_d;
            err_range_q      <= err_range_d;
            err_incomplete_q <= err_incomplete_d;
            commit_count_q   <= commit_count_d;
        end
    end

    always_comb begin
        bank_raddr = '0;
        for (int k = 0; k < N_RD; k++) begin
            bank_raddr[k*AW +: AW] = bus.rd_addr[k*TBL_AW +: AW];
        end
    end

    prob_tbl_bank #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .N_RD  (N_RD),
        .AW    (AW)
    ) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n_int),
        .we    (we0),
        .waddr (waddr),
        .wdata (bus.probability_in),
        .raddr (bank_raddr),
        .rdata (bank0_rdata)
    );

    prob_tbl_bank #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .N_RD  (N_RD),
        .AW    (AW)
    ) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n_int),
        .we    (we1),
        .waddr (waddr),
        .wdata (bus.probability_in),
        .raddr (bank_raddr),
        .rdata (bank1_rdata)
    );

    // rd_sel_q is the bank selection that was in force when the read
    // registers were loaded, so a read issued on the swap edge returns the
    // old table and the next one returns the new table.
    assign bus.rd_data = rd_sel_q ? bank1_rdata : bank0_rdata;

    assign table_valid     = table_valid_q;
    assign load_busy       = (state_q == S_LOAD);
    assign entries_written = popcount(MAX_DEPTH'(bitmap_q));
    assign err_range       = err_range_q;
    assign err_incomplete  = err_incomplete_q;
    assign commit_count    = commit_count_q;

endmodule

// File: tb/tb_prob_table_rx.sv
// ----------------------------------------------------------------------------
// tb_prob_table_rx
// Directed bench for prob_table_rx: partial and full loads, commit latency,
// range errors, atomic bank swap, back-to-back load after SWAP and reset
// in the middle of a load.
// ----------------------------------------------------------------------------
module tb_prob_table_rx;
    import prob_tbl_pkg::*;

    localparam int DEPTH = 64;
    localparam int DW    = 64;
    localparam int N_RD  = 10;

    logic        clk;
    logic        rstn;
    logic        table_valid;
    logic        load_busy;
    logic [6:0]  entries_written;
    logic        err_range;
    logic        err_incomplete;
    logic [15:0] commit_count;

    int total = 0;
    int bad   = 0;

    prob_table_rx_if #(.DW(DW), .N_RD(N_RD)) bus ();

    prob_table_rx #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .N_RD  (N_RD)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .bus             (bus),
        .table_valid     (table_valid),
        .load_busy       (load_busy),
        .entries_written (entries_written),
        .err_range       (err_range),
        .err_incomplete  (err_incomplete),
        .commit_count    (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after
    // the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] idx, input logic [63:0] data);
        bus.probability_idx = idx;
        bus.probability_in  = data;
    endtask

    task automatic set_addr(input int k, input logic [5:0] a);
        bus.rd_addr[k*TBL_AW +: TBL_AW] = a;
    endtask

    function automatic logic [63:0] rd_port(input int k);
        return bus.rd_data[k*DW +: DW];
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic tv, input logic busy,
                                input logic [6:0] ew, input logic er, input logic ei,
                                input logic [15:0] cc);
        check_output({tag, ".table_valid"},     64'(table_valid),     64'(tv));
        check_output({tag, ".load_busy"},       64'(load_busy),       64'(busy));
        check_output({tag, ".entries_written"}, 64'(entries_written), 64'(ew));
        check_output({tag, ".err_range"},       64'(err_range),       64'(er));
        check_output({tag, ".err_incomplete"},  64'(err_incomplete),  64'(ei));
        check_output({tag, ".commit_count"},    64'(commit_count),    64'(cc));
    endtask

    // Writes entries lo..hi with data base+i, one per clock.
    task automatic load_range(input int lo, input int hi, input logic [63:0] base);
        for (int i = lo; i <= hi; i++) begin
            apply_stimulus(32'(i), base + 64'(i));
            step();
        end
    endtask

    initial begin
        rstn               = 1'b0;
        bus.probability_idx = IDX_IDLE;
        bus.probability_in  = '0;
        bus.rd_addr         = '0;
        repeat (2) step();

        // Reset state
        check_status("reset", 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 16'd0);
        check_output("reset.rd0", rd_port(0), 64'd0);
        check_output("reset.rd9", rd_port(9), 64'd0);
        rstn = 1'b1;
        repeat (3) step();

        // Incomplete load of 0..62, then completion with entry 63
        load_range(0, 62, 64'h3000);
        check_output("inc.busy", 64'(load_busy), 64'd1);
        check_output("inc.ew_load", 64'(entries_written), 64'd63);
        apply_stimulus(IDX_IDLE, '0);
        step();
        step();
        check_status("inc", 1'b0, 1'b0, 7'd63, 1'b0, 1'b1, 16'd0);
        apply_stimulus(32'd63, 64'h303F);
        step();
        check_output("inc.ew_full", 64'(entries_written), 64'd64);
        check_output("inc.busy2", 64'(load_busy), 64'd1);
        apply_stimulus(IDX_IDLE, '0);
        step();
        check_output("inc.tv_check", 64'(table_valid), 64'd0);
        step();
        check_output("inc.tv_swap", 64'(table_valid), 64'd0);
        step();
        check_status("inc_done", 1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 16'd1);
        set_addr(0, 6'd10);
        step();
        check_output("inc.rd_a10", rd_port(0), 64'h300A);

        // Full load with commit latency of three edges after the last write
        load_range(0, 63, 64'h1000);
        check_output("full.ew", 64'(entries_written), 64'd64);
        apply_stimulus(IDX_IDLE, '0);
        step();
        check_output("full.cc_t1", 64'(commit_count), 64'd1);
        step();
        check_output("full.cc_t2", 64'(commit_count), 64'd1);
        step();
        check_output("full.cc_t3", 64'(commit_count), 64'd2);
        check_output("full.ew_after", 64'(entries_written), 64'd0);
        set_addr(3, 6'd42);
        step();
        check_output("full.rd3_a42", rd_port(3), 64'h102A);

        // Out-of-range indices are flagged and never written
        apply_stimulus(32'd64, 64'hDEAD);
        step();
        check_output("range.err_64", 64'(err_range), 64'd1);
        check_output("range.ew_64", 64'(entries_written), 64'd0);
        check_output("range.busy", 64'(load_busy), 64'd1);
        apply_stimulus(32'hFFFF_FFFE, 64'hDEAD);
        step();
        check_output("range.ew_fffe", 64'(entries_written), 64'd0);
        load_range(0, 63, 64'h4000);
        apply_stimulus(IDX_IDLE, '0);
        repeat (3) step();
        check_output("range.cc", 64'(commit_count), 64'd3);
        check_output("range.err_sticky", 64'(err_range), 64'd1);
        for (int a = 0; a < DEPTH; a++) begin
            set_addr(0, 6'(a));
            step();
            check_output("range.scan", rd_port(0), 64'h4000 + 64'(a));
        end

        // Atomic swap: table A (i), then table B (i+100) while reading addr 5
        load_range(0, 63, 64'd0);
        apply_stimulus(IDX_IDLE, '0);
        repeat (3) step();
        check_output("swap.cc_a", 64'(commit_count), 64'd4);
        set_addr(7, 6'd5);
        step();
        check_output("swap.pre", rd_port(7), 64'd5);
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(32'(i), 64'd100 + 64'(i));
            step();
            check_output("swap.during_load", rd_port(7), 64'd5);
        end
        apply_stimulus(IDX_IDLE, '0);
        step();
        check_output("swap.in_check", rd_port(7), 64'd5);
        step();
        check_output("swap.in_swap", rd_port(7), 64'd5);
        step();
        check_output("swap.on_toggle", rd_port(7), 64'd5);
        check_output("swap.cc_b", 64'(commit_count), 64'd5);
        step();
        check_output("swap.after", rd_port(7), 64'd105);

        // Back-to-back: write on the SWAP edge starts the next load
        load_range(0, 63, 64'h500);
        apply_stimulus(IDX_IDLE, '0);
        step();
        step();
        check_output("b2b.busy_swap", 64'(load_busy), 64'd0);
        apply_stimulus(32'd7, 64'h777);
        step();
        check_status("b2b", 1'b1, 1'b1, 7'd1, 1'b1, 1'b1, 16'd6);
        set_addr(0, 6'd7);
        apply_stimulus(IDX_IDLE, '0);
        step();
        check_output("b2b.rd_active", rd_port(0), 64'h507);
        check_output("b2b.busy_check", 64'(load_busy), 64'd0);
        step();
        check_output("b2b.ew_kept", 64'(entries_written), 64'd1);

        // Reset in the middle of a load
        load_range(0, 29, 64'h900);
        check_output("rst.ew_before", 64'(entries_written), 64'd30);
        apply_stimulus(IDX_IDLE, '0);
        rstn = 1'b0;
        #1;
        check_status("rst_async", 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 16'd0);
        check_output("rst_async.rd0", rd_port(0), 64'd0);
        repeat (2) step();
        rstn = 1'b1;
        repeat (3) step();
        step();
        check_status("post_rst", 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prob_table_rx.md
Name: prob_table_rx

Overview:
- Receiving end of the probability-table load interface. The host or bench streams (probability_idx, probability_in) pairs; idle is idx = 32'hFFFFFFFF.
- Captures the entries into a shadow bank and checks that all 64 were written before committing.
- Atomically swaps the shadow bank into the active bank.
- Serves N_RD registered read ports to the noise-injection cores of the parallel BER system.

Parameters:
- DEPTH, 64, number of table entries; must be a power of two.
- DW, 64, entry width in bits.
- N_RD, 10, number of independent read ports (one per core).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- probability_idx  in  32  write index; 32'hFFFFFFFF = idle
- probability_in  in  DW  write data, sampled with idx
- rd_addr  in  N_RD*6  packed read addresses, port k at [6k+5:6k]
- rd_data  out  N_RD*DW  packed read data, port k at [DW*k+DW-1:DW*k]
- table_valid  out  1  active bank holds a complete committed table
- load_busy  out  1  state is LOAD
- entries_written  out  7  popcount of the shadow written-bitmap
- err_range  out  1  sticky: an idx in 64..32'hFFFFFFFE was seen
- err_incomplete  out  1  sticky: load ended with the bitmap not full
- commit_count  out  16  number of successful commits, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE, bank_sel=0, bitmap=0, all outputs 0, rd_data=0. Memory contents are not reset.
- Write accept: every cycle with idx < DEPTH, shadow[idx] <= probability_in and bitmap[idx] <= 1. Rewriting the same idx overwrites the entry; the bitmap is unchanged.
- Out-of-range idx (DEPTH..FFFFFFFE): no write, err_range <= 1 (sticky until reset). Does not leave the LOAD state by itself.
- FSM states:
  - IDLE: idx != FFFFFFFF -> LOAD; the write in that cycle is accepted.
  - LOAD: idx == FFFFFFFF -> CHECK.
  - CHECK (1 cycle): if bitmap is all ones -> SWAP; else set err_incomplete, keep bitmap, -> IDLE.
  - SWAP (1 cycle): bank_sel toggles, table_valid <= 1, bitmap <= 0, commit_count++, -> IDLE.
  - A non-idle idx arriving in CHECK or SWAP is accepted into the shadow bank. CHECK uses the bitmap value before that write.
  - After SWAP, if idx is non-idle the FSM goes to LOAD instead of IDLE.
- Commit latency: last write at edge t; idle idx at edge t+1 enters CHECK; SWAP at t+2; new bank and table_valid visible at t+3.
- Partial loads retain the bitmap, so a later load may complete the missing entries and then commit.
- Read ports: rd_data_k <= active[rd_addr_k], 1-cycle latency, every cycle, independent of the FSM.
  - A read in the same cycle as the bank toggle returns the old active bank; the next cycle returns the new bank.
  - Reads never observe shadow writes.
- entries_written is combinational popcount of the registered bitmap.
- Reset mid-load: bitmap is cleared, table_valid=0, bank_sel=0; a full reload is required.

Decomposition:
- Package prob_tbl_pkg holds:
  - IDX_IDLE = 32'hFFFFFFFF
  - TBL_AW = 6
  - the state enum {S_IDLE, S_LOAD, S_CHECK, S_SWAP}
  - a localparam function for popcount
- One sub-module, prob_tbl_bank: a single DEPTH x DW bank with one synchronous write port and N_RD registered read ports. It is instantiated twice; the top module muxes write-enable and read data by bank_sel.

Test Plan:
- Full load: write idx 0..63 with data 64'h1000+i, then idx=FFFFFFFF -> table_valid rises 3 edges after the last write; commit_count=1; reading port 3 at addr 42 returns 64'h102A one cycle later.
- Incomplete load: write idx 0..62 then idle -> err_incomplete=1, table_valid=0, entries_written=63. Then write idx 63 and idle -> commit, table_valid=1, entries_written=0.
- Range error: idx=64 then idx=32'hFFFFFFFE with data 64'hDEAD -> err_range=1, entries_written unchanged, and no location reads 64'hDEAD after a later full commit.
- Atomic swap: commit table A (data=i), load table B (data=i+100) while reading addr 5 every cycle -> read returns 5 until the cycle after the SWAP edge, then 105; no intermediate value appears.
- Reset mid-load: assert rstn=0 after writing 30 entries -> all outputs 0 immediately (async); after release, a single idle cycle produces no commit and entries_written=0.
- Back-to-back: commit, then a new write on the same edge as SWAP -> FSM goes to LOAD; that entry is counted, entries_written=1 after SWAP.
